// File: rtl/down_count_mod8_pkg.sv
// Shared types and constants for the mod-8 down counter and its decrement helper.
package down_count_mod8_pkg;

    localparam int unsigned CountWidth = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/dec_mod8.sv
// Combinational 3-bit decrement with zero detect; saturates at zero so it never wraps.
module dec_mod8
    import down_count_mod8_pkg::*;
(
    input  logic [CountWidth-1:0] val_i,
    output logic [CountWidth-1:0] dec_o,
    output logic                  zero_o
);

    always_comb begin
        zero_o = (val_i == '0);
        dec_o  = zero_o ? '0 : val_i - CountWidth'(1);
    end

endmodule

// File: rtl/down_count_mod8.sv
// Mod-8 down counter with load/start control, periodic or one-shot wrap, and a registered borrow.
module down_count_mod8
    import down_count_mod8_pkg::*;
#(
    parameter logic [CountWidth-1:0] RELOAD = 3'd7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [CountWidth-1:0] din,
    input  logic                  start,
    input  logic                  mode,
    output logic [CountWidth-1:0] q,
    output logic                  bout,
    output logic                  busy,
    output logic                  done
);

    state_e                  state_q, state_d;
    logic [CountWidth-1:0]   q_q, q_d;
    logic                    bout_q, bout_d;
    logic [CountWidth-1:0]   q_dec;
    logic                    q_zero;

    dec_mod8 u_dec (
        .val_i  (q_q),
        .dec_o  (q_dec),
        .zero_o (q_zero)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        bout_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    q_d = din;
                end else if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (load) begin
                    q_d     = din;
                    state_d = StIdle;
                end else if (start) begin
                    q_d = RELOAD;
                end else if (en) begin
                    if (q_zero) begin
                        bout_d = 1'b1;
                        if (mode == MODE_ONESHOT) begin
                            state_d = StDone;
                        end else begin
                            q_d = RELOAD;
                        end
                    end else begin
                        q_d = q_dec;
                    end
                end
            end
            StDone: begin
                if (load) begin
                    q_d     = din;
                    state_d = StIdle;
                end else if (start) begin
                    q_d     = RELOAD;
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            q_q     <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            bout_q  <= bout_d;
        end
    end

    // Status flags decode the state register alone, so they cannot both be high.
    assign q    = q_q;
    assign bout = bout_q;
    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_down_count_mod8.sv
// Directed self-checking bench for down_count_mod8 with hand-computed expectations.
module tb_down_count_mod8;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic [2:0] din;
    logic       start;
    logic       mode;
    logic [2:0] q;
    logic       bout;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    down_count_mod8 #(
        .RELOAD (3'd7)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .load  (load),
        .din   (din),
        .start (start),
        .mode  (mode),
        .q     (q),
        .bout  (bout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [2:0] eq, input logic eb,
                              input logic ebusy, input logic edone);
        check({tag, ".q"}, 8'(q), 8'(eq));
        check({tag, ".bout"}, 8'(bout), 8'(eb));
        check({tag, ".busy"}, 8'(busy), 8'(ebusy));
        check({tag, ".done"}, 8'(done), 8'(edone));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; din = 3'd0; start = 1'b0; mode = 1'b0;
        #12;
        expect_out("reset", 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-run
        load = 1'b1; din = 3'd5;
        step(); expect_out("rm_load", 3'd5, 1'b0, 1'b0, 1'b0);
        load = 1'b0; start = 1'b1;
        step(); expect_out("rm_start", 3'd5, 1'b0, 1'b1, 1'b0);
        start = 1'b0; en = 1'b1;
        step(); expect_out("rm_en1", 3'd4, 1'b0, 1'b1, 1'b0);
        step(); expect_out("rm_en2", 3'd3, 1'b0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 expect_out("rm_async", 3'd0, 1'b0, 1'b0, 1'b0);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(); expect_out("rm_after", 3'd0, 1'b0, 1'b0, 1'b0);

        // One-shot from 3
        load = 1'b1; din = 3'd3;
        step(); expect_out("os_load", 3'd3, 1'b0, 1'b0, 1'b0);
        load = 1'b0; start = 1'b1; mode = 1'b1;
        step(); expect_out("os_start", 3'd3, 1'b0, 1'b1, 1'b0);
        start = 1'b0; en = 1'b1;
        step(); expect_out("os_2", 3'd2, 1'b0, 1'b1, 1'b0);
        step(); expect_out("os_1", 3'd1, 1'b0, 1'b1, 1'b0);
        step(); expect_out("os_0", 3'd0, 1'b0, 1'b1, 1'b0);
        step(); expect_out("os_bout", 3'd0, 1'b1, 1'b0, 1'b1);
        step(); expect_out("os_hold", 3'd0, 1'b0, 1'b0, 1'b1);

        // Periodic from 1 (load from DONE goes to IDLE)
        en = 1'b0; load = 1'b1; din = 3'd1;
        step(); expect_out("pe_load", 3'd1, 1'b0, 1'b0, 1'b0);
        load = 1'b0; start = 1'b1; mode = 1'b0;
        step(); expect_out("pe_start", 3'd1, 1'b0, 1'b1, 1'b0);
        start = 1'b0; en = 1'b1;
        step(); expect_out("pe_0", 3'd0, 1'b0, 1'b1, 1'b0);
        step(); expect_out("pe_wrap", 3'd7, 1'b1, 1'b1, 1'b0);
        step(); expect_out("pe_6", 3'd6, 1'b0, 1'b1, 1'b0);
        step(); expect_out("pe_5", 3'd5, 1'b0, 1'b1, 1'b0);
        step(); expect_out("pe_4", 3'd4, 1'b0, 1'b1, 1'b0);

        // Enable gaps from 4
        en = 1'b1; step(); expect_out("gap_a", 3'd3, 1'b0, 1'b1, 1'b0);
        en = 1'b0; step(); expect_out("gap_b", 3'd3, 1'b0, 1'b1, 1'b0);
        en = 1'b1; step(); expect_out("gap_c", 3'd2, 1'b0, 1'b1, 1'b0);
        en = 1'b0; step(); expect_out("gap_d", 3'd2, 1'b0, 1'b1, 1'b0);

        // Priority: load beats start and en at q=2
        en = 1'b1; load = 1'b1; start = 1'b1; din = 3'd6;
        step(); expect_out("prio", 3'd6, 1'b0, 1'b0, 1'b0);

        // Start with q=0 in one-shot
        en = 1'b0; start = 1'b0; din = 3'd0;
        step(); expect_out("z_load", 3'd0, 1'b0, 1'b0, 1'b0);
        load = 1'b0; start = 1'b1; mode = 1'b1;
        step(); expect_out("z_start", 3'd0, 1'b0, 1'b1, 1'b0);
        start = 1'b0; en = 1'b1;
        step(); expect_out("z_bout", 3'd0, 1'b1, 1'b0, 1'b1);
        en = 1'b0; start = 1'b1;
        step(); expect_out("z_restart", 3'd7, 1'b0, 1'b1, 1'b0);

        // Restart in RUN ignores en
        start = 1'b1; en = 1'b1;
        step(); expect_out("restart_run", 3'd7, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        step(); expect_out("after_restart", 3'd6, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
